// File: rtl/fft32_sdiv_28s_14s_16_seq.sv
// fft32_sdiv_28s_14s_16_seq
// Sequential signed divider for the fft32 output-normalisation path. It takes
// a signed dividend and a signed divisor and returns a saturated signed
// quotient plus a remainder. The quotient truncates toward zero and the
// remainder takes the dividend's sign. Internally it is a restoring radix-2
// datapath on operand magnitudes that retires one quotient bit per cycle.
//
// Optional build macro: FFT32_SDIV_ROUND_EN
//   Defined   - the quotient rounds to nearest, with ties away from zero.
//               The remainder output still reports the truncating remainder.
//   Undefined - truncation toward zero only.
//
// Ports
//   ap_clk, ap_rst        rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready is high only in IDLE)
//   dividend, divisor     signed operands
//   out_valid / out_ready result handshake; outputs hold while stalled
//   quotient, remainder   signed results
//   div_by_zero           the divisor was zero for this result
//   overflow              the true quotient did not fit and was clamped
module fft32_sdiv_28s_14s_16_seq #(
    parameter int DIVIDEND_W = 28,
    parameter int DIVISOR_W  = 14,
    parameter int QUOT_W     = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    // One extra bit so that the rounding increment cannot wrap.
    localparam int QM_W  = DIVIDEND_W + 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIVIDEND_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [QM_W-1:0]   POS_MAX  = QM_W'((2 ** (QUOT_W - 1)) - 1);
    localparam logic [QM_W-1:0]   NEG_MAX  = QM_W'(2 ** (QUOT_W - 1));
    localparam logic [QUOT_W-1:0] Q_POS    = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] Q_NEG    = {1'b1, {(QUOT_W-1){1'b0}}};

    // S_SIGN is the single DONE-entry cycle in which signs, rounding and
    // saturation are applied. S_DONE holds the result until out_ready.
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    // The dividend magnitude shifts out of the MSB while quotient bits shift
    // into the LSB. After the last step this register holds |quotient|.
    logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]    rem_q, rem_d;
    logic [DIVISOR_W-1:0]    dsr_q, dsr_d;
    logic                    dvd_neg_q, dvd_neg_d;
    logic                    dsr_neg_q, dsr_neg_d;
    logic                    out_valid_q, out_valid_d;
    logic [QUOT_W-1:0]       quot_q, quot_d;
    logic [DIVISOR_W-1:0]    remo_q, remo_d;
    logic                    dbz_q, dbz_d;
    logic                    ovf_q, ovf_d;

    logic [DIVISOR_W:0]      shifted;
    logic                    ge;
    logic [DIVISOR_W-1:0]    sub;
    logic [QM_W-1:0]         qmag;
    logic                    q_neg;
    logic [QUOT_W-1:0]       q_fin;
    logic                    q_ovf;
    logic [DIVISOR_W-1:0]    r_fin;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dsr_neg_q   <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            remo_q      <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            dvd_neg_q   <= dvd_neg_d;
            dsr_neg_q   <= dsr_neg_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            remo_q      <= remo_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // One restoring step. When the subtraction succeeds, the true difference
    // is below |divisor| <= 2^(DIVISOR_W-1), so a modular DIVISOR_W-bit
    // subtract is exact.
    always_comb begin
        shifted = {rem_q, dvd_q[DIVIDEND_W-1]};
        ge      = (shifted >= {1'b0, dsr_q});
        sub     = shifted[DIVISOR_W-1:0] - dsr_q;
    end

    // Sign, rounding and saturation. These only matter in S_SIGN.
    always_comb begin
        qmag = {1'b0, dvd_q};
`ifdef FFT32_SDIV_ROUND_EN
        // Round half away from zero on the magnitude, before sign and clamp.
        if ({rem_q, 1'b0} >= {1'b0, dsr_q}) begin
            qmag = qmag + QM_W'(1);
        end
`endif
        q_neg = dvd_neg_q ^ dsr_neg_q;
        q_ovf = 1'b0;
        if (!q_neg) begin
            if (qmag > POS_MAX) begin
                q_fin = Q_POS;
                q_ovf = 1'b1;
            end else begin
                q_fin = qmag[QUOT_W-1:0];
            end
        end else begin
            if (qmag > NEG_MAX) begin
                q_fin = Q_NEG;
                q_ovf = 1'b1;
            end else begin
                // A magnitude of exactly 2^(QUOT_W-1) negates to itself,
                // which is the most negative code, as intended.
                q_fin = -qmag[QUOT_W-1:0];
            end
        end
        r_fin = dvd_neg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        dvd_neg_d   = dvd_neg_q;
        dsr_neg_d   = dsr_neg_q;
        out_valid_d = out_valid_q;
        quot_d      = quot_q;
        remo_d      = remo_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // The negation of the most negative dividend is still
                    // correct when the result is read as unsigned.
                    dvd_neg_d = dividend[DIVIDEND_W-1];
                    dsr_neg_d = divisor[DIVISOR_W-1];
                    dvd_d     = dividend[DIVIDEND_W-1] ? -dividend : dividend;
                    dsr_d     = divisor[DIVISOR_W-1] ? -divisor : divisor;
                    rem_d     = '0;
                    cnt_d     = CNT_LOAD;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                dvd_d = {dvd_q[DIVIDEND_W-2:0], ge};
                rem_d = ge ? sub : shifted[DIVISOR_W-1:0];
                if (cnt_q == '0) begin
                    state_d = S_SIGN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SIGN: begin
                // A zero divisor still ran the full loop, which keeps the
                // latency fixed. Its result is replaced here.
                if (dsr_q == '0) begin
                    quot_d = dvd_neg_q ? Q_NEG : Q_POS;
                    remo_d = '0;
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
                end else begin
                    quot_d = q_fin;
                    remo_d = r_fin;
                    dbz_d  = 1'b0;
                    ovf_d  = q_ovf;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/fft32_sdiv_28s_14s_16_seq.md
Name: fft32_sdiv_28s_14s_16_seq

Overview:
Sequential signed divider that undoes the width growth of the FFT twiddle multiply. It takes a 28-bit signed product and a 14-bit signed scale and returns a saturated 16-bit signed quotient plus remainder. Used on the fft32 output-normalisation path. It uses a restoring radix-2 datapath, produces one quotient bit per cycle, and has a valid/ready handshake on both sides.

Parameters:
DIVIDEND_W, 28, dividend width (signed)
DIVISOR_W, 14, divisor width (signed); also the remainder width
QUOT_W, 16, output quotient width (signed, saturated)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  synchronous active-high reset
in_valid  in  1  dividend/divisor valid
in_ready  out  1  block can accept; high only in IDLE
dividend  in  DIVIDEND_W  signed dividend
divisor  in  DIVISOR_W  signed divisor
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
quotient  out  QUOT_W  signed quotient, saturated
remainder  out  DIVISOR_W  signed remainder
div_by_zero  out  1  divisor was 0 for this result
overflow  out  1  true quotient outside QUOT_W signed range

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; overflow=0.
- IDLE:
  - in_valid&&in_ready: capture operands.
  - Store |dividend| as DIVIDEND_W-bit unsigned, |divisor| as DIVISOR_W-bit unsigned, and both signs.
  - Load step counter with DIVIDEND_W-1, then go to CALC.
- CALC: each cycle, shift the next magnitude bit (MSB first) into the partial remainder and trial-subtract |divisor|.
  - Non-negative result: keep the difference, quotient bit=1.
  - Otherwise: quotient bit=0.
  - After the counter reaches 0: go to DONE.
- DONE entry: apply signs, then saturation.
  - Quotient negated iff the operand signs differ (truncation toward zero).
  - Remainder takes the dividend's sign; |remainder| < |divisor| always.
  - Full-magnitude quotient > 2^(QUOT_W-1)-1 (positive) or < -2^(QUOT_W-1) (negative): clamp to 32767 / -32768 and set overflow=1.
- Divisor==0: computation still runs to keep latency fixed; outputs forced to quotient=32767 if dividend>=0 else -32768, remainder=0, div_by_zero=1, overflow=0.
- Latency: out_valid rises exactly DIVIDEND_W+1 cycles after the accepting edge (29 at defaults).
- Output hold: quotient, remainder and flags are stable while out_valid=1 and out_ready=0.
- DONE exit: out_valid&&out_ready → IDLE, out_valid=0 next cycle. Output registers keep their last value.
- Throughput: at most one operation per DIVIDEND_W+2 cycles. in_ready=0 in CALC and DONE; in_valid there is ignored, not queued.
- out_ready high before out_valid has no effect.
- ap_rst mid-CALC or in DONE aborts the operation: the next cycle is IDLE with all outputs at reset values. An in_valid sampled together with ap_rst is dropped.
- Extremes:
  - dividend=-2^27 gives magnitude 2^27, representable as unsigned.
  - divisor=-2^13 gives magnitude 2^13, no special case.

Optional Feature:
FFT32_SDIV_ROUND_EN
- Defined: quotient rounds to nearest, ties away from zero. If 2*|rem| >= |divisor|, the quotient magnitude is incremented before sign and saturation; the increment can itself trigger saturation/overflow. The remainder output still reports the truncating remainder. Latency unchanged; rounding is done in the DONE-entry cycle.
- Undefined: truncation toward zero only; no rounding logic present.

Test Plan:
- 1000 / 7 → quotient 142, remainder 6, flags 0. out_valid at accept+29. With FFT32_SDIV_ROUND_EN: quotient 143, remainder 6.
- -1000 / 7 → quotient -142, remainder -6; 1000 / -7 → -142, remainder 6. With the macro, also 21 / 6 → 4 (tie, 3.5 away from zero) and -21 / 6 → -4.
- 134217727 / 1 → quotient 32767, overflow=1; -134217728 / -8192 → quotient 16384, remainder 0, overflow=0; -134217728 / 1 → -32768, overflow=1.
- 500 / 0 → quotient 32767, div_by_zero=1; -500 / 0 → -32768, div_by_zero=1; both at the normal 29-cycle latency.
- Backpressure on 1000/7: hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, an extra in_valid pulse is ignored. out_ready=1 → IDLE next cycle, then a new operand pair is accepted.
- Reset mid-operation: assert ap_rst at cycle 12 of CALC → next cycle IDLE, out_valid=0, in_ready=1, outputs 0. A fresh 1000/7 then completes normally.
